// File: rtl/addsub_result_stage_if.sv
// Handshake bundle between the upstream adder, the result stage and its consumer.
interface addsub_result_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] answer;
  logic             carry_out;
  logic             overflow;
  logic             sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [4:0]       out_flags;

  modport master (
    output in_valid, answer, carry_out, overflow, sat_en, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, answer, carry_out, overflow, sat_en, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/addsub_result_stage.sv
// Result stage behind the add/sub unit: optional saturation, NZCV flag
// generation, a 2-entry skid FIFO and sticky overflow statistics.
module addsub_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addsub_result_stage_if.slave bus,
  input  logic                 clr_sticky,
  output logic                 ovf_sticky,
  output logic [CNT_W-1:0]     ovf_count
);

  localparam logic signed [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]        CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // An overflowed sum has the wrong sign bit, so the clamp direction is its inverse.
  function automatic logic signed [WIDTH-1:0] saturate(
    input logic signed [WIDTH-1:0] value,
    input logic                    do_sat
  );
    if (!do_sat) return value;
    return value[WIDTH-1] ? SAT_MAX : SAT_MIN;
  endfunction

  function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  endfunction

  logic signed [WIDTH-1:0] answer_s;
  logic signed [WIDTH-1:0] result_p0;
  logic                    sat_p0;
  logic [4:0]              flags_p0;
  logic                    push;
  logic                    pop;
  logic                    ovf_push;

  logic signed [WIDTH-1:0] result_p1 [0:1];
  logic [4:0]              flags_p1  [0:1];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              occ;
  logic [1:0]              occ_next;
  logic                    vld_p1;

  // ---- stage p0: shape the incoming adder result ----
  assign answer_s  = bus.answer;
  assign sat_p0    = bus.overflow && bus.sat_en;
  assign result_p0 = saturate(answer_s, sat_p0);
  assign flags_p0  = {sat_p0, result_p0[WIDTH-1], (result_p0 == '0),
                      bus.carry_out, bus.overflow};

  assign bus.in_ready = rst_n && (occ != 2'd2);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = vld_p1 && bus.out_ready;
  assign ovf_push     = push && bus.overflow;

  always_comb begin
    occ_next = occ;
    unique case ({push, pop})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // ---- stage p1: FIFO storage and control ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      occ <= occ_next;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      result_p1[wr_ptr] <= result_p0;
      flags_p1[wr_ptr]  <= flags_p0;
    end
  end

  // A same-cycle clear and overflow leaves exactly that one event recorded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (clr_sticky) begin
      ovf_sticky <= ovf_push;
      ovf_count  <= ovf_push ? CNT_ONE : '0;
    end else if (ovf_push) begin
      ovf_sticky <= 1'b1;
      ovf_count  <= count_inc(ovf_count);
    end
  end

  // ---- output: head entry, forced to zero when the FIFO is empty ----
  assign vld_p1         = (occ != 2'd0);
  assign bus.out_valid  = vld_p1;
  assign bus.out_result = vld_p1 ? result_p1[rd_ptr] : '0;
  assign bus.out_flags  = vld_p1 ? flags_p1[rd_ptr]  : 5'd0;

endmodule

// File: tb/tb_addsub_result_stage.sv
// Directed and randomized scoreboard bench for addsub_result_stage.
module tb_addsub_result_stage;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_sticky;
  logic       ovf_sticky;
  logic [7:0] ovf_count;

  addsub_result_stage_if #(.WIDTH(32)) bus ();

  addsub_result_stage #(.WIDTH(32), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  logic [36:0] sb[$];
  logic        m_sticky;
  logic [7:0]  m_cnt;

  function automatic logic [36:0] exp_entry(input logic [31:0] a, input logic c,
                                            input logic v, input logic s);
    logic [31:0] r;
    logic        st;
    st = v && s;
    r  = st ? (a[31] ? 32'h7FFF_FFFF : 32'h8000_0000) : a;
    return {r, st, r[31], (r == 32'd0), c, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic c,
                       input logic o, input logic s);
    bus.in_valid  = v;
    bus.answer    = a;
    bus.carry_out = c;
    bus.overflow  = o;
    bus.sat_en    = s;
  endtask

  // One clock: check outputs against the scoreboard, update model, step, check stats.
  task automatic tick();
    logic        push_m, pop_m, ovf_m;
    logic [36:0] head;
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(rst_n && (sb.size() < 2)));
    chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      head = sb[0];
      chk("out_result", 64'(bus.out_result), 64'(head[36:5]));
      chk("out_flags", 64'(bus.out_flags), 64'(head[4:0]));
    end
    push_m = rst_n && bus.in_valid && (sb.size() < 2);
    pop_m  = rst_n && bus.out_ready && (sb.size() != 0);
    ovf_m  = push_m && bus.overflow;
    if (!rst_n) begin
      sb.delete();
      m_sticky = 1'b0;
      m_cnt    = 8'd0;
    end else begin
      if (pop_m) void'(sb.pop_front());
      if (push_m) sb.push_back(exp_entry(bus.answer, bus.carry_out, bus.overflow, bus.sat_en));
      if (clr_sticky) begin
        m_sticky = ovf_m;
        m_cnt    = ovf_m ? 8'd1 : 8'd0;
      end else if (ovf_m) begin
        m_sticky = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
    end
    @(posedge clk);
    #1;
    chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
    chk("ovf_count", 64'(ovf_count), 64'(m_cnt));
  endtask

  initial begin
    rst_n         = 1'b0;
    clr_sticky    = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, 32'd0, 0, 0, 0);
    m_sticky = 1'b0;
    m_cnt    = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_result", 64'(bus.out_result), 64'd0);
    chk("rst_out_flags", 64'(bus.out_flags), 64'd0);
    chk("rst_sticky", 64'(ovf_sticky), 64'd0);
    chk("rst_count", 64'(ovf_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // Plain sum 1011+1027, one-cycle latency
    bus.out_ready = 1'b1;
    drive(1, 32'h0000_07F6, 0, 0, 0); tick(); drive(0, 32'd0, 0, 0, 0);
    chk("sum_valid", 64'(bus.out_valid), 64'd1);
    chk("sum_result", 64'(bus.out_result), 64'h7F6);
    chk("sum_flags", 64'(bus.out_flags), 64'b00000);
    tick();

    // Negative-looking overflow, saturated then raw
    drive(1, 32'h8000_0000, 0, 1, 1); tick(); drive(0, 32'd0, 0, 0, 0);
    chk("sat_result", 64'(bus.out_result), 64'h7FFF_FFFF);
    chk("sat_flags", 64'(bus.out_flags), 64'b10001);
    chk("sat_sticky", 64'(ovf_sticky), 64'd1);
    chk("sat_count", 64'(ovf_count), 64'd1);
    tick();
    drive(1, 32'h8000_0000, 0, 1, 0); tick(); drive(0, 32'd0, 0, 0, 0);
    chk("raw_result", 64'(bus.out_result), 64'h8000_0000);
    chk("raw_flags", 64'(bus.out_flags), 64'b01001);
    tick();
    drive(1, 32'h7FFF_FFF0, 1, 1, 1); tick(); drive(0, 32'd0, 0, 0, 0);
    chk("satneg_result", 64'(bus.out_result), 64'h8000_0000);
    chk("satneg_flags", 64'(bus.out_flags), 64'b11011);
    tick();

    // x - x: zero with carry
    drive(1, 32'h0000_0000, 1, 0, 0); tick(); drive(0, 32'd0, 0, 0, 0);
    chk("zero_flags", 64'(bus.out_flags), 64'b00110);
    tick();

    // Backpressure: A, B fill, C refused, then drain
    bus.out_ready = 1'b0;
    drive(1, 32'h0000_00AA, 0, 0, 0); tick();
    drive(1, 32'h0000_00BB, 0, 0, 0); tick();
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1, 32'h0000_00CC, 0, 0, 0); tick(); drive(0, 32'd0, 0, 0, 0);
    chk("hold_A", 64'(bus.out_result), 64'hAA);
    tick();
    bus.out_ready = 1'b1;
    tick();
    chk("drain_B", 64'(bus.out_result), 64'hBB);
    chk("drain_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("drain_empty", 64'(bus.out_valid), 64'd0);

    // Counter saturation and clear-with-overflow
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1, 32'(i), 0, 1, 0);
      tick();
    end
    drive(0, 32'd0, 0, 0, 0);
    chk("cnt_hold_255", 64'(ovf_count), 64'd255);
    tick();
    clr_sticky = 1'b1;
    drive(1, 32'h8000_0000, 0, 1, 1); tick();
    clr_sticky = 1'b0;
    drive(0, 32'd0, 0, 0, 0);
    chk("clr_ovf_count", 64'(ovf_count), 64'd1);
    chk("clr_ovf_sticky", 64'(ovf_sticky), 64'd1);
    tick();

    // Reset with two queued entries
    bus.out_ready = 1'b0;
    drive(1, 32'h0000_1111, 0, 0, 0); tick();
    drive(1, 32'h0000_2222, 0, 0, 0); tick();
    drive(0, 32'd0, 0, 0, 0);
    rst_n = 1'b0; tick();
    chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    drive(1, 32'h0000_3333, 0, 1, 0); tick();
    drive(0, 32'd0, 0, 0, 0);
    rst_n = 1'b1;
    drive(1, 32'h0000_4444, 0, 0, 0); tick(); drive(0, 32'd0, 0, 0, 0);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
    chk("post_rst_result", 64'(bus.out_result), 64'h4444);
    tick();

    // Random mix of traffic, backpressure and clears
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.out_ready = 1'($urandom_range(0, 1));
      clr_sticky    = ($urandom_range(0, 9) == 0);
      tick();
    end
    drive(0, 32'd0, 0, 0, 0);
    clr_sticky    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
